// File: rtl/somador_serial_ctrl_if.sv
// Handshake and operand/result bundle between a requester and the
// bit-serial adder controller.
interface somador_serial_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] R;
  logic         Cout;
  logic         V;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B, Cin,
    input  R, Cout, V, busy, done
  );

  modport slave (
    input  start, A, B, Cin,
    output R, Cout, V, busy, done
  );
endinterface

// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder: one full-adder cell walked LSB-first over N cycles,
// with a start/busy/done handshake and registered sum, carry and overflow.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SOMA  | one operand bit added per edge, carry held in a flip-flop
// FIM   | result valid, done pulses for this single cycle

module SomadorCompleto (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic R,
  output logic Cout
);
  assign R    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module somador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  somador_serial_ctrl_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t         state_q;
  logic [N-1:0]   opa_q;
  logic [N-1:0]   opb_q;
  logic [N-1:0]   acc_q;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;
  logic           cout_q;
  logic           v_q;
  logic           busy_q;
  logic           done_q;

  logic           sum_bit;
  logic           cell_cout;
  logic [N-1:0]   acc_d;
  logic           last_bit;

  SomadorCompleto u_cell (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Cin  (carry_q),
    .R    (sum_bit),
    .Cout (cell_cout)
  );

  // Sum bits enter at the MSB so that after N shifts bit 0 lands at acc[0].
  assign acc_d    = {sum_bit, acc_q[N-1:1]};
  assign last_bit = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa_q   <= bus.A;
            opb_q   <= bus.B;
            carry_q <= bus.Cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SOMA;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SOMA: begin
          acc_q   <= acc_d;
          carry_q <= cell_cout;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            // carry_q here is still the carry into the MSB.
            r_q     <= acc_d;
            cout_q  <= cell_cout;
            v_q     <= cell_cout ^ carry_q;
            done_q  <= 1'b1;
            state_q <= FIM;
          end
        end
        FIM: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.R    = r_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl: directed and random operations
// on an 8-bit instance, plus an exhaustive sweep on a 4-bit instance.
module tb_somador_serial_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  somador_serial_ctrl_if #(.N(8)) bus8 ();
  somador_serial_ctrl_if #(.N(4)) bus4 ();

  somador_serial_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  somador_serial_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_r8;

  // Reference: plain integer addition, signed overflow from the signed sum range.
  function automatic void model(input int n, input int a, input int b, input int c,
                                output int r, output bit co, output bit v);
    int s, sa, sb, ss, half;
    half = 1 << (n - 1);
    s    = a + b + c;
    r    = s % (1 << n);
    co   = (s >= (1 << n));
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    ss   = sa + sb + c;
    v    = (ss >= half) || (ss < -half);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] r, output logic co, output logic v,
                     output int lat, output int busy_n, output int done_n);
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = a; bus8.B = b; bus8.Cin = c;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.Cin = 1'($urandom);
    lat = -1; busy_n = 0; done_n = 0; r = 'x; co = 1'bx; v = 1'bx;
    for (int k = 0; k <= 12; k++) begin
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; r = bus8.R; co = bus8.Cout; v = bus8.V;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                     output logic [3:0] r, output logic co, output logic v,
                     output int lat, output int done_n);
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = a; bus4.B = b; bus4.Cin = c;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.A = 4'($urandom); bus4.B = 4'($urandom); bus4.Cin = 1'($urandom);
    lat = -1; done_n = 0; r = 'x; co = 1'bx; v = 1'bx;
    for (int k = 0; k <= 7; k++) begin
      if (bus4.done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; r = bus4.R; co = bus4.Cout; v = bus4.V;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus8.R, bus8.Cout, bus8.V, bus8.busy, bus8.done} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset8: got R=%h C=%b V=%b busy=%b done=%b, want all 0",
               bus8.R, bus8.Cout, bus8.V, bus8.busy, bus8.done);
    end
    n_checks++;
    if ({bus4.R, bus4.Cout, bus4.V, bus4.busy, bus4.done} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset4: got R=%h C=%b V=%b busy=%b done=%b, want all 0",
               bus4.R, bus4.Cout, bus4.V, bus4.busy, bus4.done);
    end
    // start presented together with release must be taken on the next edge
    rst = 1'b0; bus8.start = 1'b1; bus8.A = 8'h01; bus8.B = 8'h02;
    @(negedge clk);
    bus8.start = 1'b0;
    n_checks++;
    if (bus8.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start_after_reset: busy=%b, want 1", bus8.busy);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus8.R !== 8'h03) begin
      n_fail++;
      $display("FAIL first_op_result: R=%h, want 03", bus8.R);
    end
    last_r8 = bus8.R;
  endtask

  task automatic test_basic();
    logic [7:0] r; logic co, v; int lat, busy_n, done_n;
    op8(8'h3C, 8'h42, 1'b0, r, co, v, lat, busy_n, done_n);
    n_checks++;
    if ({co, v, r} !== {1'b0, 1'b0, 8'h7E}) begin
      n_fail++;
      $display("FAIL basic_result: got C=%b V=%b R=%h, want C=0 V=0 R=7e", co, v, r);
    end
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    n_checks++;
    if (busy_n !== 9) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, want 9", busy_n);
    end
    n_checks++;
    if (done_n !== 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: got %0d, want 1", done_n);
    end
    last_r8 = r;
  endtask

  task automatic test_boundaries();
    logic [7:0] r; logic co, v; int lat, busy_n, done_n;
    op8(8'hFF, 8'h00, 1'b1, r, co, v, lat, busy_n, done_n);
    n_checks++;
    if ({co, v, r} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_carry: got C=%b V=%b R=%h, want C=1 V=0 R=00", co, v, r);
    end
    op8(8'h7F, 8'h01, 1'b0, r, co, v, lat, busy_n, done_n);
    n_checks++;
    if ({co, v, r} !== {1'b0, 1'b1, 8'h80}) begin
      n_fail++;
      $display("FAIL signed_overflow: got C=%b V=%b R=%h, want C=0 V=1 R=80", co, v, r);
    end
    last_r8 = r;
  endtask

  task automatic test_back_to_back();
    int er1, er2; bit ec1, ev1, ec2, ev2;
    logic [7:0] prev, want_r;
    int done_ks[$];
    prev = last_r8;
    model(8, 'h11, 'h22, 1, er1, ec1, ev1);
    model(8, 'hC8, 'h64, 0, er2, ec2, ev2);
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'h11; bus8.B = 8'h22; bus8.Cin = 1'b1;
    for (int k = 0; k <= 2 * 8 + 5; k++) begin
      @(negedge clk);
      if (k < 8)           want_r = prev;
      else if (k < 2*8+2)  want_r = 8'(er1);
      else                 want_r = 8'(er2);
      n_checks++;
      if (bus8.R !== want_r) begin
        n_fail++;
        $display("FAIL held_R k=%0d: R=%h, want %h", k, bus8.R, want_r);
      end
      if (bus8.done) begin
        done_ks.push_back(k);
        n_checks++;
        if ({bus8.Cout, bus8.V} !== (k < 2*8+2 ? {ec1, ev1} : {ec2, ev2})) begin
          n_fail++;
          $display("FAIL held_flags k=%0d: C=%b V=%b", k, bus8.Cout, bus8.V);
        end
      end
      if (k == 8 + 1) begin
        bus8.A = 8'hC8; bus8.B = 8'h64; bus8.Cin = 1'b0;
      end else begin
        bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.Cin = 1'($urandom);
      end
      if (k == 8 + 2) bus8.start = 1'b0;
    end
    n_checks++;
    if (done_ks.size() != 2 || done_ks[0] != 8 || done_ks[1] != 2*8+2) begin
      n_fail++;
      $display("FAIL held_done_timing: %0d pulses, want pulses at k=8 and k=18",
               done_ks.size());
    end
    last_r8 = bus8.R;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r; logic co, v; int lat, busy_n, done_n;
    int busy_seen, done_seen;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'hAA; bus8.B = 8'h55; bus8.Cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus8.R, bus8.Cout, bus8.V, bus8.busy, bus8.done} !== 12'h0) begin
      n_fail++;
      $display("FAIL async_reset: R=%h C=%b V=%b busy=%b done=%b, want all 0",
               bus8.R, bus8.Cout, bus8.V, bus8.busy, bus8.done);
    end
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.busy) busy_seen++;
      if (bus8.done) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      n_fail++;
      $display("FAIL reset_discard: done=%0d busy=%0d cycles, want 0", done_seen, busy_seen);
    end
    op8(8'h12, 8'h34, 1'b0, r, co, v, lat, busy_n, done_n);
    n_checks++;
    if ({co, v, r} !== {1'b0, 1'b0, 8'h46} || lat !== 8) begin
      n_fail++;
      $display("FAIL post_reset_op: C=%b V=%b R=%h lat=%0d, want 0 0 46 8", co, v, r, lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, r; logic c, co, v; int lat, busy_n, done_n;
    int er; bit ec, ev;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      model(8, int'(a), int'(b), int'(c), er, ec, ev);
      op8(a, b, c, r, co, v, lat, busy_n, done_n);
      n_checks++;
      if ({co, v, r} !== {ec, ev, 8'(er)} || done_n !== 1) begin
        n_fail++;
        $display("FAIL random8 %h+%h+%b: C=%b V=%b R=%h done=%0d, want C=%b V=%b R=%h done=1",
                 a, b, c, co, v, r, done_n, ec, ev, 8'(er));
      end
    end
  endtask

  task automatic test_sweep4();
    logic [3:0] r; logic co, v; int lat, done_n;
    int er; bit ec, ev;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          model(4, a, b, c, er, ec, ev);
          op4(4'(a), 4'(b), 1'(c), r, co, v, lat, done_n);
          n_checks++;
          if ({co, r} !== {ec, 4'(er)}) begin
            n_fail++;
            $display("FAIL sweep4_sum %0d+%0d+%0d: got %h, want %h", a, b, c, {co, r}, {ec, 4'(er)});
          end
          n_checks++;
          if (v !== ev) begin
            n_fail++;
            $display("FAIL sweep4_V %0d+%0d+%0d: got %b, want %b", a, b, c, v, ev);
          end
          n_checks++;
          if (done_n !== 1 || lat !== 4) begin
            n_fail++;
            $display("FAIL sweep4_done %0d+%0d+%0d: pulses=%0d lat=%0d, want 1 and 4",
                     a, b, c, done_n, lat);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_op();
    test_random8();
    test_sweep4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/somador_serial_ctrl.md
# somador_serial_ctrl

Bit-serial adder controller for the ULA datapath. It sequences a single `SomadorCompleto` 1-bit full-adder instance over N clock cycles to add two N-bit operands, LSB first. It keeps the carry between bits in a flip-flop and reports completion through a start/busy/done handshake. Use it where area matters more than latency, and as the reference sequencer for the adder cell inside the ULA.

## Interface
Parameters:
- `N`, default 8: operand width in bits; legal range N ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `start`  input  1: request an addition; sampled only in IDLE.
- `A`  input  N: operand A; captured on the edge that accepts `start`.
- `B`  input  N: operand B; captured on the same edge as `A`.
- `Cin`  input  1: initial carry-in; captured on the same edge as `A`.
- `R`  output  N: registered sum result.
- `Cout`  output  1: registered carry out of bit N-1.
- `V`  output  1: registered signed overflow, equal to the carry into bit N-1 XOR the carry out of bit N-1.
- `busy`  output  1: high in states SOMA and FIM.
- `done`  output  1: one-cycle pulse while in FIM.

## Operation
- Exactly one `SomadorCompleto` instance (ports A, B, Cin, R, Cout) carries all the arithmetic. No `+` operator is used on the operands.
- Internal registers:
  - `opA`, `opB`: N-bit right-shift registers.
  - `carry`: 1-bit carry flip-flop.
  - `acc`: N-bit sum shift register.
  - `cnt`: index counter, width clog2(N).
  - `cprev`: carry into the current bit.
- The adder cell is driven by `opA[0]`, `opB[0]` and `carry`.

State machine:
- **IDLE:** `busy`=0, `done`=0.
  - If `start`=1: load `opA`←A, `opB`←B, `carry`←Cin, `cnt`←0, go to SOMA.
  - Otherwise stay in IDLE.
- **SOMA:** every edge does the following:
  - shift the cell's sum bit into `acc[N-1]` (acc shifts right);
  - `carry`←cell Cout, `cprev`←`carry`;
  - shift `opA` and `opB` right by one;
  - increment `cnt`.
  - On the edge where `cnt`==N-1 (the last bit), also load `R`←final acc, `Cout`←cell Cout, `V`←cell Cout XOR `carry`, and go to FIM.
- **FIM:** `done`=1 for exactly this cycle; the next edge always returns to IDLE.

Rules:
- `start` is ignored in SOMA and FIM. It is not queued; a request must be re-asserted in IDLE.
- `A`, `B` and `Cin` may change freely after capture without affecting the operation in flight.
- `R`, `Cout` and `V` change only on entry to FIM and hold that value until the next FIM. They never show intermediate values.
- The result is modulo 2^N. `Cout` equals bit N of the full sum A+B+Cin.
- Reset can be asserted in any state and takes effect immediately, without waiting for a clock edge:
  - state goes to IDLE;
  - `R`, `Cout`, `V`, `busy`, `done`, `cnt`, `carry` and `acc` go to 0;
  - an operation in flight is discarded and no `done` pulse follows.
- Deasserting `rst` leaves the block in IDLE; the first `start` can be accepted on the first rising edge after release.

## Timing
- Call the edge that accepts `start` edge t.
- Bits 0..N-1 are computed on edges t+1 .. t+N.
- `busy` is high from just after edge t through to edge t+N+1.
- `done` is high between edges t+N and t+N+1, with `R`, `Cout` and `V` already valid during that window.
- Latency from the `start` edge to `done` is N cycles. Throughput is one operation every N+2 cycles, with `start` held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- N=8, A=0x3C, B=0x42, Cin=0, pulse `start` → `done` 8 cycles later; R=0x7E, Cout=0, V=0; `busy` high for 9 cycles.
- N=8, A=0xFF, B=0x00, Cin=1 → R=0x00, Cout=1, V=0. Then A=0x7F, B=0x01, Cin=0 → R=0x80, Cout=0, V=1.
- Hold `start`=1 continuously and change A/B during SOMA → only operands present at acceptance are used; the next acceptance occurs on the edge after FIM; R holds its previous value until the new FIM.
- Assert `rst` asynchronously at the 3rd SOMA cycle of an operation with A=0xAA, B=0x55 → all outputs 0 immediately; no `done` pulse; a new `start` after release produces a correct result.
- N=4, exhaustive sweep of all A, B, Cin (512 cases) → {Cout,R} equals A+B+Cin, V matches the signed-overflow reference, `done` asserted exactly once per operation.
